// File: rtl/gate_test_ctrl_if.sv
// rtl/gate_test_ctrl_if.sv - control, result and gate-drive signals of the gate test sequencer
interface gate_test_ctrl_if;
  logic       start;
  logic       abort;
  logic [3:0] truth;
  logic       gate_a;
  logic       gate_b;
  logic       gate_c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  // Board / bench side: issues commands and closes the loop through the gate
  modport master (
    output start, abort, truth, gate_c,
    input  gate_a, gate_b, busy, done, pass, err_count, fail_vec
  );

  // Sequencer side
  modport slave (
    input  start, abort, truth, gate_c,
    output gate_a, gate_b, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_test_ctrl.sv
// rtl/gate_test_ctrl.sv - steps a 2-input gate through all four vectors and checks its truth table
module gate_test_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  gate_test_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // The settle counter runs SETTLE_CYCLES-1 down to 0, giving SETTLE_CYCLES cycles in SETTLE
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [1:0] idx_q;
  logic [3:0] exp_q;
  logic [7:0] settle_q;
  logic [1:0] drive_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [2:0] err_q;
  logic [3:0] fail_q;

  logic       mismatch_d;
  logic [2:0] err_d;
  logic [3:0] fail_d;

  // Result values after folding in the compare of the vector currently held on the gate
  always_comb begin
    mismatch_d = (bus.gate_c != exp_q[idx_q]);
    err_d      = err_q + {2'b00, mismatch_d};
    fail_d     = fail_q | ({3'b000, mismatch_d} << idx_q);
  end

  // Sequencer: abort outranks start, reset outranks everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      exp_q    <= 4'd0;
      settle_q <= 8'd0;
      drive_q  <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 3'd0;
      fail_q   <= 4'd0;
    end else if (bus.abort) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      drive_q  <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 3'd0;
      fail_q   <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_DRIVE;
            idx_q   <= 2'd0;
            exp_q   <= bus.truth;
            drive_q <= 2'd0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
          end
        end
        ST_DRIVE: begin
          settle_q <= SETTLE_LOAD;
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == 8'd0) begin
            state_q <= ST_CHECK;
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        ST_CHECK: begin
          err_q  <= err_d;
          fail_q <= fail_d;
          if (idx_q == 2'd3) begin
            // Results become visible on the same edge that raises done
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 3'd0);
          end else begin
            idx_q   <= idx_q + 2'd1;
            drive_q <= idx_q + 2'd1;
            state_q <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          idx_q   <= 2'd0;
          drive_q <= 2'd0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gate_a    = drive_q[1];
  assign bus.gate_b    = drive_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_test_ctrl.sv
// tb/tb_gate_test_ctrl.sv - randomized scoreboard bench for gate_test_ctrl
module tb_gate_test_ctrl;

  localparam int S   = 4;
  localparam int RUN = 4 * (S + 2);

  typedef struct {
    logic [3:0] fv;
    int         err;
    int         e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] gate_tbl;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  exp_t exp_q[$];

  gate_test_ctrl_if bus ();

  gate_test_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // The gate under test: whatever table the bench installs, indexed by {a,b}
  assign bus.gate_c = gate_tbl[{bus.gate_a, bus.gate_b}];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_ab"}, int'({bus.gate_a, bus.gate_b}), 0);
    chk({tag, "_pass"}, int'(bus.pass), 0);
    chk({tag, "_err"}, int'(bus.err_count), 0);
    chk({tag, "_fail"}, int'(bus.fail_vec), 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.e0 + RUN);
        chk("fail_vec", int'(bus.fail_vec), int'(e.fv));
        chk("err_count", int'(bus.err_count), e.err);
        chk("pass", int'(bus.pass), int'(e.err == 0));
      end
    end
  end

  // mode 0: plain run; 1: truth change and stray starts mid-run;
  // 2: abort+start at E0+8, then a start that must be accepted; 3: reset at E0+12
  task automatic run(input logic [3:0] tr, input logic [3:0] tbl, input int mode);
    int e0;
    int dc0;
    logic [3:0] efv;
    int eerr;
    efv  = tr ^ tbl;
    eerr = $countones(efv);
    gate_tbl = tbl;
    @(negedge clk);
    bus.truth = tr;
    bus.start = 1'b1;
    e0  = cyc + 1;
    dc0 = done_cnt;
    if (mode < 2) exp_q.push_back('{efv, eerr, e0});
    for (int rel = 0; rel < RUN + 6; rel++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (mode == 1 && rel == 4) bus.truth = 4'b0000;
      if (mode == 1 && (rel == 9 || rel == RUN)) bus.start = 1'b1;
      if (mode == 2 && rel == 7) begin
        bus.abort = 1'b1;
        bus.start = 1'b1;
      end
      if (mode == 2 && rel == 8) begin
        bus.abort = 1'b0;
        chk_cleared("abort");
        bus.start = 1'b1;
      end
      if (mode == 2 && rel == 9) begin
        chk("restart_busy", int'(bus.busy), 1);
        bus.abort = 1'b1;
      end
      if (mode == 2 && rel == 10) begin
        bus.abort = 1'b0;
        chk("reabort_busy", int'(bus.busy), 0);
      end
      if (mode == 3 && rel == 11) rst = 1'b1;
      if (mode == 3 && rel == 12) begin
        rst = 1'b0;
        chk_cleared("reset");
      end
      if (mode < 2 && rel % (S + 2) == 0 && rel <= RUN) begin
        chk("busy_run", int'(bus.busy), 1);
        if (rel < RUN) chk("drive_ab", int'({bus.gate_a, bus.gate_b}), rel / (S + 2));
      end
      if (mode < 2 && rel == RUN + 1) begin
        chk("busy_end", int'(bus.busy), 0);
        chk("drive_end", int'({bus.gate_a, bus.gate_b}), 0);
      end
    end
    chk("done_pulses", done_cnt - dc0, (mode < 2) ? 1 : 0);
    if (mode < 2) begin
      chk("hold_fail", int'(bus.fail_vec), int'(efv));
      chk("hold_err", int'(bus.err_count), eerr);
      chk("hold_pass", int'(bus.pass), int'(eerr == 0));
    end
  endtask

  initial begin
    logic [3:0] tr;
    logic [3:0] tbl;
    rst       = 1'b1;
    gate_tbl  = 4'b0000;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.truth = 4'b0000;
    repeat (3) @(negedge clk);
    chk_cleared("rst_state");
    rst = 1'b0;
    @(negedge clk);

    run(4'b1000, 4'b1000, 0);
    run(4'b1000, 4'b0000, 0);
    run(4'b0110, 4'b1000, 0);
    run(4'b1000, 4'b1000, 1);
    run(4'b1000, 4'b0001, 3);
    run(4'b1000, 4'b1000, 0);
    run(4'b1000, 4'b0001, 2);
    run(4'b0110, 4'b0110, 0);

    for (int n = 0; n < 16; n++) begin
      tr  = 4'($urandom_range(0, 15));
      tbl = ($urandom_range(0, 2) == 0) ? tr : 4'($urandom_range(0, 15));
      run(tr, tbl, (n % 4 == 3) ? 1 : 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_test_ctrl.md
# gate_test_ctrl

Self-checking stimulus sequencer for a single 2-input combinational gate (AND, OR, XOR, and similar lab gates).
- On a start pulse it drives all four input combinations onto the gate.
- After a programmable settle time it samples the gate output for each combination and compares it against a 4-bit expected truth table.
- It reports a per-vector fail mask, an error count and a pass flag.
- It sits beside the gate under test on the lab board top level and replaces hand-written `#delay` stimulus with a clocked, repeatable check.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: clock cycles the inputs are held stable before the output is checked. Legal range is 1..255.

Ports:
- `clk`  input  1  system clock; all logic is rising-edge.
- `rst`  input  1  reset, synchronous and active-high.
- `start`  input  1  start request. Accepted only in IDLE.
- `abort`  input  1  synchronous abort. Returns the block to IDLE from any state.
- `truth`  input  4  expected gate output. `truth[i]` is the expected `gate_c` for `{gate_a,gate_b}=i` (AND = 4'b1000).
- `gate_a`  output  1  registered drive to gate input a.
- `gate_b`  output  1  registered drive to gate input b.
- `gate_c`  input  1  gate output under test.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse when a full run completes.
- `pass`  output  1  high when the last completed run had zero mismatches.
- `err_count`  output  3  number of mismatching vectors in the last run (0..4).
- `fail_vec`  output  4  bit i set when vector i mismatched.

## Operation
State machine:
- **IDLE**
  - `start`=1 and `abort`=0 → DRIVE, with `idx`←0.
  - On that edge: latch `truth` into `exp_r`, clear `err_count`, `fail_vec` and `pass`, and set `{gate_a,gate_b}`←2'b00.
- **DRIVE**
  - One cycle; inputs already applied.
  - Load `settle_cnt`←`SETTLE_CYCLES`−1 and go to SETTLE.
- **SETTLE**
  - Decrement `settle_cnt` each cycle.
  - Go to CHECK when `settle_cnt`==0, so SETTLE lasts exactly `SETTLE_CYCLES` cycles.
- **CHECK**
  - One cycle. At the exit edge, compare `gate_c` with `exp_r[idx]`.
  - On mismatch: set `fail_vec[idx]` and increment `err_count`.
  - `idx`==3 → DONE. Otherwise `idx`←`idx`+1, `{gate_a,gate_b}`←`idx`+1, and go to DRIVE.
- **DONE**
  - One cycle with `done`=1.
  - `pass`←(`err_count` including the final compare ==0).
  - `gate_a`/`gate_b` return to 0. Go to IDLE.

Rules:
- `truth` is sampled only at start. Changes during a run are ignored.
- `start` is ignored in every state except IDLE, including the DONE cycle. It is not queued.
- `abort`:
  - Takes effect on the next edge: go to IDLE, set `gate_a`=`gate_b`=0, and clear `err_count`, `fail_vec` and `pass`.
  - No `done` pulse is issued.
  - `abort` has priority over `start` in the same cycle.
- `rst` has priority over everything. On the edge where `rst`=1, all registers take their reset values, even mid-run.
- Reset values: `gate_a`=0, `gate_b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, state=IDLE, `idx`=0.
- `err_count` cannot exceed 4, so no saturation logic is needed.
- Results hold their values from DONE until the next accepted start, abort or reset.

## Timing
- Edge E0 is the edge that accepts `start`. Vector k is driven from edge E0+k·(`SETTLE_CYCLES`+2).
- Each vector lasts `SETTLE_CYCLES`+2 cycles (1 DRIVE + `SETTLE_CYCLES` + 1 CHECK).
- `gate_c` for vector k is sampled at edge E0+(k+1)·(`SETTLE_CYCLES`+2).
  - This gives `SETTLE_CYCLES`+2 cycles of settling before the sample.
- `done` is high in the cycle following edge E0+4·(`SETTLE_CYCLES`+2). For `SETTLE_CYCLES`=4 that is the cycle after E0+24.
- `pass`, `err_count` and `fail_vec` are valid from the same edge that raises `done`.
- `busy` rises at E0 and falls at the edge ending DONE.
- Total run length is 4·(`SETTLE_CYCLES`+2)+1 cycles of `busy`.

## Test plan
1. Ideal AND model on `gate_c`, `truth`=4'b1000, `SETTLE_CYCLES`=4, one start pulse:
   - `{a,b}` steps 00, 01, 10, 11 at 6-cycle spacing.
   - `done` pulses once, 24 edges after E0.
   - `pass`=1, `err_count`=0, `fail_vec`=4'b0000.
2. `gate_c` stuck at 0, `truth`=4'b1000 → `pass`=0, `err_count`=1, `fail_vec`=4'b1000.
3. AND model with `truth`=4'b0110 (XOR table) → `fail_vec`=4'b1110, `err_count`=3, `pass`=0.
4. Start a run, then:
   - Pulse `start` again at E0+10 → ignored; exactly one `done` at E0+24, with the same results as scenario 1.
   - Change `truth` to 4'b0000 at E0+5 → results are unchanged.
5. Assert `rst` at E0+12 → on the next edge all outputs are 0 and the state is IDLE, with no `done`. A new start then completes a full run correctly.
6. Assert `abort` at E0+8 together with `start` → IDLE, `gate_a`/`gate_b`=0, `busy`=0, results cleared, no `done`. A start on the following cycle is accepted.
